weight_preload_dma: RTL

//  Responder side of the weight preload handshake: accepts preload_req/base/count from the weight loader,

---
 rtl/weight_preload_dma.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/weight_preload_dma.sv
`timescale 1ns/1ps
// weight_preload_dma
//   Responder side of the weight preload handshake. On preload_req it fetches
//   preload_count 128-bit words from memory starting at preload_base, using an
//   AXI4 read-only master (AR/R channels). The words are written into the
//   weight buffer from address 0 upward, and preload_done pulses once the last
//   word has been written.
//
// Ports
//   clk, rst_n                      clock and async active-low reset
//   preload_req/base/count          level request and transfer descriptor
//   preload_done                    1-cycle completion pulse
//   busy                            high from accept until preload_done
//   err_resp                        sticky SLVERR/DECERR flag, cleared on accept
//   err_ovf                         sticky clamp flag, cleared on accept
//   m_ar*, m_r*                     AXI4 read address / read data channels
//   bram_we/addr/wdata              weight buffer write port
module weight_preload_dma #(
  parameter int ADDR_W     = 32,
  parameter int BUF_ADDR_W = 15,
  parameter int MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  preload_req,
  input  logic [ADDR_W-1:0]     preload_base,
  input  logic [16:0]           preload_count,
  output logic                  preload_done,
  output logic                  busy,
  output logic                  err_resp,
  output logic                  err_ovf,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [127:0]          m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  bram_we,
  output logic [BUF_ADDR_W-1:0] bram_addr,
  output logic [127:0]          bram_wdata
);

  localparam logic [17:0] DEPTH   = 18'(2 ** BUF_ADDR_W);
  localparam logic [17:0] MAX_BST = 18'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_FIN,
    S_REL
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   addr;
  logic [17:0]         rem;
  logic [BUF_ADDR_W:0] wptr;
  logic [17:0]         count_ext;
  logic [17:0]         bnd;
  logic [17:0]         beats;
  logic [17:0]         rem_dec;
  logic                accept;
  logic                beat;
  logic                unused_ok;

  assign count_ext = {1'b0, preload_count};
  assign accept    = (state == S_IDLE) && preload_req;
  assign beat      = (state == S_R) && m_rvalid;
  assign unused_ok = ^{preload_base[3:0], wptr[BUF_ADDR_W], m_rresp[0]};

  // Burst length: limited by remaining words, MAX_BURST, and the number of
  // 16-byte beats left before the next 4 KB boundary.
  always_comb begin
    bnd   = (18'd4096 - {6'd0, addr[11:0]}) >> 4;
    beats = rem;
    if (beats > MAX_BST) beats = MAX_BST;
    if (beats > bnd)     beats = bnd;
    // Extra beats past the clamp (slave sends more than asked) are dropped,
    // so rem saturates at zero and wptr can never wrap.
    rem_dec = (rem != '0) ? rem - 18'd1 : rem;
  end

  assign m_arvalid = (state == S_AR);
  assign m_araddr  = m_arvalid ? addr : '0;
  assign m_arlen   = m_arvalid ? 8'(beats - 18'd1) : '0;
  assign m_arsize  = 3'd4;
  assign m_arburst = 2'b01;
  assign m_rready  = (state == S_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (preload_req) state_nxt = (count_ext == '0) ? S_FIN : S_AR;
      S_AR:   if (m_arready) state_nxt = S_R;
      S_R:    if (m_rvalid && m_rlast) state_nxt = (rem_dec != '0) ? S_AR : S_FIN;
      S_FIN:  state_nxt = S_REL;
      S_REL:  if (!preload_req) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      rem          <= '0;
      wptr         <= '0;
      busy         <= 1'b0;
      err_resp     <= 1'b0;
      err_ovf      <= 1'b0;
      preload_done <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_wdata   <= '0;
    end else begin
      bram_we      <= 1'b0;
      preload_done <= 1'b0;
      if (accept) begin
        addr     <= {preload_base[ADDR_W-1:4], 4'b0000};
        rem      <= (count_ext > DEPTH) ? DEPTH : count_ext;
        wptr     <= '0;
        err_resp <= 1'b0;
        err_ovf  <= (count_ext > DEPTH);
        busy     <= 1'b1;
      end
      if (beat) begin
        if (rem != '0) begin
          bram_we    <= 1'b1;
          bram_addr  <= wptr[BUF_ADDR_W-1:0];
          bram_wdata <= m_rdata;
          wptr       <= wptr + 1'b1;
          addr       <= addr + ADDR_W'(16);
        end
        rem <= rem_dec;
        if (m_rresp[1]) err_resp <= 1'b1;
      end
      // FIN lasts one cycle so the final registered write lands first.
      if (state == S_FIN) begin
        preload_done <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end

endmodule
